// File: rtl/serial_sub.sv
// serial_sub: bit-serial ripple subtractor {bout, a - b - bin}, LSB first, start/ready/done handshake
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   start : request, sampled only while ready
//   a, b  : minuend / subtrahend, captured on accepted start
//   bin   : borrow-in, captured on accepted start
//   ready : idle, start will be accepted
//   busy  : shifting operand bits
//   done  : one-cycle pulse, diff valid from this cycle on
//   diff  : {bout, difference}, held until the next completion
module serial_sub #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W:0]   diff
);
  localparam int CW = $clog2(W);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t        state;
  logic [W-1:0]  a_sh, b_sh, res_sh;
  logic          brw, d;
  logic [CW-1:0] cnt;
  assign d     = a_sh[0] ^ b_sh[0] ^ brw;
  assign ready = state == IDLE;
  assign busy  = state == SHIFT;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      done   <= 1'b0;
      diff   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a_sh  <= a;
          b_sh  <= b;
          brw   <= bin;
          cnt   <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          brw    <= (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw);
          res_sh <= {d, res_sh[W-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) state <= DONE;
        end
        DONE: begin
          diff  <= {brw, res_sh};
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: randomized and directed self-checking bench for serial_sub against an arithmetic model
module tb_serial_sub;
  localparam int W = 4;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         ready, busy, done;
  logic [W:0]   diff;
  int checks = 0;
  int errors = 0;

  serial_sub #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .ready(ready), .busy(busy), .done(done), .diff(diff)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] model(input int x, input int y, input int z);
    int t;
    t = x - y - z;
    return {(x < y + z) ? 1'b1 : 1'b0, W'(t & ((1 << W) - 1))};
  endfunction

  task automatic scramble();
    a   = W'($urandom);
    b   = W'($urandom);
    bin = 1'($urandom);
  endtask

  task automatic wait_done(output logic [W:0] r, output int lat);
    lat = 0;
    r   = 'x;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        r   = diff;
        break;
      end
    end
    checks++;
    if (lat == 0) begin
      errors++;
      $display("FAIL done_timeout: no done within 20 cycles");
    end
  endtask

  task automatic run_op(input int x, input int y, input int z, output logic [W:0] r, output int lat);
    for (int k = 0; k < 20 && !ready; k++) @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout: ready=%b required 1", ready);
    end
    start = 1'b1;
    a     = W'(x);
    b     = W'(y);
    bin   = 1'(z);
    @(negedge clk);
    start = 1'b0;
    scramble();
    wait_done(r, lat);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (diff !== '0 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: diff=%b ready=%b busy=%b done=%b required 00000 1 0 0", diff, ready, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    int v[4][3] = '{'{9, 3, 0}, '{3, 9, 0}, '{0, 0, 1}, '{15, 0, 0}};
    logic [W:0] exp_v[4] = '{5'b00110, 5'b11010, 5'b11111, 5'b01111};
    logic [W:0] r;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(v[i][0], v[i][1], v[i][2], r, lat);
      checks++;
      if (r !== exp_v[i]) begin
        errors++;
        $display("FAIL directed_%0d: diff=%b required %b", i, r, exp_v[i]);
      end
      checks++;
      if (lat != W + 1) begin
        errors++;
        $display("FAIL latency_%0d: done after %0d edges required %0d", i, lat, W + 1);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || diff !== exp_v[i]) begin
        errors++;
        $display("FAIL done_pulse_%0d: done=%b diff=%b required 0 %b", i, done, diff, exp_v[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [W:0] r;
    int lat;
    @(negedge clk);
    start = 1'b1;
    a = 4'd9;
    b = 4'd3;
    bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_shift: busy=%b required 1", busy);
    end
    start = 1'b1;
    a = 4'd1;
    b = 4'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(r, lat);
    checks++;
    if (r !== 5'b00110) begin
      errors++;
      $display("FAIL ignore_start: diff=%b required 00110", r);
    end
    for (int k = 0; k < W + 3; k++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || ready !== 1'b1) begin
        errors++;
        $display("FAIL no_extra_op: done=%b ready=%b required 0 1", done, ready);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [W:0] r;
    int lat;
    @(negedge clk);
    start = 1'b1;
    a = 4'd12;
    b = 4'd5;
    bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (diff !== '0 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: diff=%b ready=%b busy=%b done=%b required 00000 1 0 0", diff, ready, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(7, 2, 0, r, lat);
    checks++;
    if (r !== 5'b00101) begin
      errors++;
      $display("FAIL after_reset: diff=%b required 00101", r);
    end
  endtask

  task automatic test_exhaustive();
    logic [W:0] r;
    int lat;
    for (int x = 0; x < (1 << W); x++)
      for (int y = 0; y < (1 << W); y++)
        for (int z = 0; z < 2; z++) begin
          run_op(x, y, z, r, lat);
          checks++;
          if (r !== model(x, y, z)) begin
            errors++;
            $display("FAIL exhaustive a=%0d b=%0d bin=%0d: diff=%b required %b", x, y, z, r, model(x, y, z));
          end
        end
  endtask

  task automatic test_back_to_back();
    logic [W:0] q[$];
    int last = -1;
    int accepts = 0;
    int dones = 0;
    @(negedge clk);
    scramble();
    start = 1'b1;
    for (int c = 0; c < 400 && dones < 10; c++) begin
      if (done) begin
        dones++;
        checks++;
        if (q.size() == 0 || diff !== q[0]) begin
          errors++;
          $display("FAIL b2b_result_%0d: diff=%b required %b", dones, diff, q.size() ? q[0] : 'x);
        end
        if (q.size() != 0) void'(q.pop_front());
      end
      if (ready && accepts < 10) begin
        q.push_back(model(a, b, bin));
        if (last >= 0) begin
          checks++;
          if (c - last != W + 2) begin
            errors++;
            $display("FAIL b2b_period: %0d cycles required %0d", c - last, W + 2);
          end
        end
        last = c;
        accepts++;
      end else begin
        scramble();
        if (accepts == 10) start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (dones != 10 || q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: dones=%0d pending=%0d required 10 0", dones, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
    test_exhaustive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
